regfile_wb_arbiter: RTL and testbench

Write-back arbiter and load scoreboard for the RV32 register file. Two producers compete for the single register-file write port: the ALU result path and the load/store unit return path. The block grants one of them per cycle and drives the register file's EN/A3/WD3 from a registered write stage. It also tracks destination registers of outstanding loads and gives decode a read-after-write stall.

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter and load scoreboard for the RV32
// register file. Grants ALU or LSU onto the single write port through a
// registered write stage, tracks pending load destinations and raises a
// decode RAW stall.
// Optional feature: define WBARB_ROUND_ROBIN_EN for alternating grants
// under contention (default build is fixed priority, LSU wins).
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ALU_VALID,
  input  logic [AW-1:0]     ALU_RD,
  input  logic [XLEN-1:0]   ALU_DATA,
  output logic              ALU_READY,
  input  logic              LSU_VALID,
  input  logic [AW-1:0]     LSU_RD,
  input  logic [XLEN-1:0]   LSU_DATA,
  output logic              LSU_READY,
  input  logic              ISSUE_LD,
  input  logic [AW-1:0]     ISSUE_RD,
  output logic              ISSUE_READY,
  input  logic [AW-1:0]     A1,
  input  logic [AW-1:0]     A2,
  output logic              STALL,
  output logic              EN,
  output logic [AW-1:0]     A3,
  output logic [XLEN-1:0]   WD3,
  output logic [2**AW-1:0]  BUSY,
  output logic              ERR
);

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t              wb_req, wb_q;
  logic             alu_gnt, lsu_gnt, xfer, issue_acc;
  logic [2**AW-1:0] busy_q, busy_nxt;
  logic             err_q;

`ifdef WBARB_ROUND_ROBIN_EN
  // rr_alu=1 means the ALU is preferred on the next contended cycle
  logic rr_alu;

  // Preferred requester wins a tie; a lone requester always wins
  always_comb begin
    lsu_gnt = LSU_VALID && !(ALU_VALID && rr_alu);
    alu_gnt = ALU_VALID && !(LSU_VALID && !rr_alu);
  end

  // Hand preference to the other side after every transfer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          rr_alu <= 1'b0;
    else if (lsu_gnt) rr_alu <= 1'b1;
    else if (alu_gnt) rr_alu <= 1'b0;
  end
`else
  // Fixed priority: LSU always wins, ALU may starve
  always_comb begin
    lsu_gnt = LSU_VALID;
    alu_gnt = ALU_VALID && !LSU_VALID;
  end
`endif

  assign xfer      = lsu_gnt | alu_gnt;
  assign LSU_READY = lsu_gnt;
  assign ALU_READY = alu_gnt;

  // Mux the granted requester; x0 targets are acknowledged but never written
  always_comb begin
    wb_req.rd   = lsu_gnt ? LSU_RD   : ALU_RD;
    wb_req.data = lsu_gnt ? LSU_DATA : ALU_DATA;
    wb_req.en   = xfer && (wb_req.rd != '0);
  end

  // Write stage: address/data hold when nothing is written
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_q <= '0;
    end else begin
      wb_q.en <= wb_req.en;
      if (wb_req.en) begin
        wb_q.rd   <= wb_req.rd;
        wb_q.data <= wb_req.data;
      end
    end
  end

  assign EN  = wb_q.en;
  assign A3  = wb_q.rd;
  assign WD3 = wb_q.data;

  assign ISSUE_READY = (ISSUE_RD == '0) || !busy_q[ISSUE_RD];
  assign issue_acc   = ISSUE_LD && ISSUE_READY && (ISSUE_RD != '0);

  // Scoreboard next state: clear on load return, set on load issue
  always_comb begin
    busy_nxt = busy_q;
    if (lsu_gnt)   busy_nxt[LSU_RD]   = 1'b0;
    if (issue_acc) busy_nxt[ISSUE_RD] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard and sticky error for a return to a register with no pending load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (lsu_gnt && (LSU_RD != '0) && !busy_q[LSU_RD]) err_q <= 1'b1;
    end
  end

  assign BUSY = busy_q;
  assign ERR  = err_q;

  // RAW stall: pending load, or a write in flight the regfile cannot yet return
  assign STALL = ((A1 != '0) && (busy_q[A1] || (wb_q.en && wb_q.rd == A1))) ||
                 ((A2 != '0) && (busy_q[A2] || (wb_q.en && wb_q.rd == A2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench with a write-back scoreboard.
module tb_regfile_wb_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_VALID, LSU_VALID, ISSUE_LD;
  logic [4:0]  ALU_RD, LSU_RD, ISSUE_RD, A1, A2;
  logic [31:0] ALU_DATA, LSU_DATA;
  logic        ALU_READY, LSU_READY, ISSUE_READY, STALL, EN, ERR;
  logic [4:0]  A3;
  logic [31:0] WD3, BUSY;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int errs    = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA), .LSU_READY(LSU_READY),
    .ISSUE_LD(ISSUE_LD), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
    .A1(A1), .A2(A2), .STALL(STALL),
    .EN(EN), .A3(A3), .WD3(WD3), .BUSY(BUSY), .ERR(ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a3 = a;
    e.wd = d;
    sb.push_back(e);
  endtask

  // Every register-file write must match the oldest expected write
  always @(negedge CLK) begin
    if (EN === 1'b1) begin
      chk("wb_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_a3", 32'(A3), 32'(e.a3));
        chk("wb_wd3", WD3, e.wd);
      end
    end
  end

  initial begin
    RST = 1'b1;
    ALU_VALID = 0; ALU_RD = 0; ALU_DATA = 0;
    LSU_VALID = 0; LSU_RD = 0; LSU_DATA = 0;
    ISSUE_LD = 0; ISSUE_RD = 0; A1 = 0; A2 = 0;
    cyc(); cyc();
    RST = 1'b0;
    #1;
    chk("rst_en", 32'(EN), 32'd0);
    chk("rst_a3", 32'(A3), 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_busy", BUSY, 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_issue_ready", 32'(ISSUE_READY), 32'd1);

    // ALU write to x5, then RAW stall while the write is in flight
    cyc();
    ALU_VALID = 1; ALU_RD = 5; ALU_DATA = 32'hDEADBEEF;
    #1;
    chk("alu_ready", 32'(ALU_READY), 32'd1);
    chk("alu_lsu_ready", 32'(LSU_READY), 32'd0);
    push(5, 32'hDEADBEEF);
    cyc();
    ALU_VALID = 0; A1 = 5;
    #1;
    chk("alu_en", 32'(EN), 32'd1);
    chk("alu_a3", 32'(A3), 32'd5);
    chk("alu_stall", 32'(STALL), 32'd1);
    cyc();
    chk("alu_stall_done", 32'(STALL), 32'd0);
    chk("alu_a3_hold", 32'(A3), 32'd5);
    A1 = 0;

    // Load issue to x7, repeat issue blocked, LSU return clears
    ISSUE_LD = 1; ISSUE_RD = 7;
    #1;
    chk("ld_issue_ready", 32'(ISSUE_READY), 32'd1);
    cyc();
    A2 = 7;
    #1;
    chk("ld_busy7", BUSY, 32'h80);
    chk("ld_stall", 32'(STALL), 32'd1);
    chk("ld_issue_blocked", 32'(ISSUE_READY), 32'd0);
    cyc();
    ISSUE_LD = 0;
    LSU_VALID = 1; LSU_RD = 7; LSU_DATA = 32'h1234;
    #1;
    chk("ld_busy7_hold", BUSY, 32'h80);
    chk("ld_lsu_ready", 32'(LSU_READY), 32'd1);
    push(7, 32'h1234);
    cyc();
    LSU_VALID = 0;
    #1;
    chk("ld_busy_clr", BUSY, 32'd0);
    chk("ld_err", 32'(ERR), 32'd0);
    chk("ld_stall_inflight", 32'(STALL), 32'd1);
    cyc();
    chk("ld_stall_clr", 32'(STALL), 32'd0);
    A2 = 0;

    // x0 transfer and x0 issue: acknowledged, no write, no busy, no error
    LSU_VALID = 1; LSU_RD = 0; LSU_DATA = 32'h55;
    ISSUE_LD = 1; ISSUE_RD = 0;
    #1;
    chk("x0_lsu_ready", 32'(LSU_READY), 32'd1);
    chk("x0_issue_ready", 32'(ISSUE_READY), 32'd1);
    cyc();
    LSU_VALID = 0; ISSUE_LD = 0;
    #1;
    chk("x0_en", 32'(EN), 32'd0);
    chk("x0_busy", BUSY, 32'd0);
    chk("x0_err", 32'(ERR), 32'd0);

    // Issue x4, then issue x3 together with the x4 return
    ISSUE_LD = 1; ISSUE_RD = 4;
    cyc();
    ISSUE_RD = 3;
    LSU_VALID = 1; LSU_RD = 4; LSU_DATA = 32'h44;
    #1;
    chk("mix_lsu_ready", 32'(LSU_READY), 32'd1);
    chk("mix_issue_ready", 32'(ISSUE_READY), 32'd1);
    cyc();
    ISSUE_LD = 0; LSU_VALID = 0;
    #1;
    chk("mix_busy3", BUSY, 32'h8);
    chk("mix_en", 32'(EN), 32'd1);
    // Reset lands while the x4 write is in the write stage: it is dropped
    RST = 1;
    #1;
    chk("mrst_en", 32'(EN), 32'd0);
    chk("mrst_busy", BUSY, 32'd0);
    chk("mrst_a3", 32'(A3), 32'd0);
    chk("mrst_wd3", WD3, 32'd0);
    cyc();
    RST = 0;
    cyc();

    // Contention: ALU x1 vs LSU x2
    ALU_VALID = 1; ALU_RD = 1; ALU_DATA = 32'h11;
    LSU_VALID = 1; LSU_RD = 2; LSU_DATA = 32'h22;
    #1;
    chk("arb1_lsu", 32'(LSU_READY), 32'd1);
    chk("arb1_alu", 32'(ALU_READY), 32'd0);
    push(2, 32'h22);
`ifdef WBARB_ROUND_ROBIN_EN
    cyc();
    chk("arb2_lsu", 32'(LSU_READY), 32'd0);
    chk("arb2_alu", 32'(ALU_READY), 32'd1);
    push(1, 32'h11);
    cyc();
    chk("arb3_lsu", 32'(LSU_READY), 32'd1);
    chk("arb3_alu", 32'(ALU_READY), 32'd0);
    push(2, 32'h22);
    cyc();
    ALU_VALID = 0; LSU_VALID = 0;
`else
    cyc();
    LSU_VALID = 0;
    #1;
    chk("arb2_lsu", 32'(LSU_READY), 32'd0);
    chk("arb2_alu", 32'(ALU_READY), 32'd1);
    push(1, 32'h11);
    cyc();
    ALU_VALID = 0;
    #1;
    chk("arb3_alu", 32'(ALU_READY), 32'd0);
`endif
    cyc();
    // Clear the error raised by the unmatched contention returns
    RST = 1;
    cyc();
    RST = 0;
    #1;
    chk("rst2_err", 32'(ERR), 32'd0);

    // Return to non-busy x9: write still happens, error is sticky
    LSU_VALID = 1; LSU_RD = 9; LSU_DATA = 32'h99;
    #1;
    chk("err_lsu_ready", 32'(LSU_READY), 32'd1);
    push(9, 32'h99);
    cyc();
    LSU_VALID = 0;
    #1;
    chk("err_set", 32'(ERR), 32'd1);
    chk("err_en", 32'(EN), 32'd1);
    chk("err_a3", 32'(A3), 32'd9);
    cyc();
    chk("err_sticky", 32'(ERR), 32'd1);
    chk("err_en_off", 32'(EN), 32'd0);
    cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
